// File: rtl/huffman_decoder_if.sv
// Table-load, bitstream and symbol handshake bundle for the Huffman decoder.
// The master drives table writes, control and bits; the slave is the decoder.
interface huffman_decoder_if #(parameter int AW = 4);
  logic          tbl_we;
  logic [AW-1:0] tbl_addr;
  logic [7:0]    tbl_sym;
  logic [7:0]    tbl_code;
  logic [2:0]    tbl_len;
  logic          start;
  logic          stop;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic [7:0]    sym_out;
  logic          sym_valid;
  logic          sym_ready;
  logic [7:0]    sym_count;
  logic          done;
  logic          err;

  modport master (
    output tbl_we, tbl_addr, tbl_sym, tbl_code, tbl_len,
    output start, stop, bit_in, bit_valid, sym_ready,
    input  bit_ready, sym_out, sym_valid, sym_count, done, err
  );

  modport slave (
    input  tbl_we, tbl_addr, tbl_sym, tbl_code, tbl_len,
    input  start, stop, bit_in, bit_valid, sym_ready,
    output bit_ready, sym_out, sym_valid, sym_count, done, err
  );
endinterface

// File: rtl/huffman_decoder.sv
// Streaming MSB-first Huffman decoder: loadable table of up to NSYM codes
// (1..7 bits), parallel match per incoming bit, one symbol out per codeword.
module huffman_decoder #(
  parameter int NSYM = 16,
  parameter int AW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  huffman_decoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, OUT, ERR} state_t;

  state_t     state_q, state_d;
  logic [7:0] tsym_q  [NSYM];
  logic [7:0] tcode_q [NSYM];
  logic [2:0] tlen_q  [NSYM];

  logic [6:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sym_out_q, sym_out_d;
  logic [7:0] sym_count_q, sym_count_d;
  logic       sym_valid_q, sym_valid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [6:0] nacc;
  logic [2:0] ncnt;
  logic       hit;
  logic [7:0] hit_sym;
  logic       bit_ready;

  function automatic logic [6:0] len_mask(input logic [2:0] l);
    logic [7:0] m;
    m = (8'd1 << l) - 8'd1;
    return m[6:0];
  endfunction

  // Table storage; len==0 marks an entry invalid, so reset only needs to
  // guarantee that, but everything is cleared for determinism.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSYM; i++) begin
        tsym_q[i]  <= '0;
        tcode_q[i] <= '0;
        tlen_q[i]  <= '0;
      end
    end else if (state_q == IDLE && bus.tbl_we && int'(bus.tbl_addr) < NSYM) begin
      tsym_q[bus.tbl_addr]  <= bus.tbl_sym;
      tcode_q[bus.tbl_addr] <= bus.tbl_code;
      tlen_q[bus.tbl_addr]  <= bus.tbl_len;
    end
  end

  // Parallel match on the accumulator including the incoming bit; scanning
  // downward lets the lowest matching index win.
  always_comb begin
    nacc    = {acc_q[5:0], bus.bit_in};
    ncnt    = cnt_q + 3'd1;
    hit     = 1'b0;
    hit_sym = '0;
    for (int i = NSYM - 1; i >= 0; i--) begin
      if (tlen_q[i] != 3'd0 && tlen_q[i] == ncnt &&
          ((tcode_q[i][6:0] ^ nacc) & len_mask(tlen_q[i])) == 7'd0) begin
        hit     = 1'b1;
        hit_sym = tsym_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sym_out_q   <= '0;
      sym_count_q <= '0;
      sym_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sym_out_q   <= sym_out_d;
      sym_count_q <= sym_count_d;
      sym_valid_q <= sym_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sym_out_d   = sym_out_q;
    sym_count_d = sym_count_q;
    sym_valid_d = sym_valid_q;
    done_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE, ERR: begin
        sym_valid_d = 1'b0;
        if (bus.start) begin
          state_d     = RUN;
          acc_d       = '0;
          cnt_d       = '0;
          sym_count_d = '0;
          err_d       = 1'b0;
        end
      end
      RUN: begin
        // stop outranks a pending bit; a partial codeword is an error
        if (bus.stop) begin
          if (cnt_q == 3'd0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end else if (bus.bit_valid) begin
          if (hit) begin
            sym_out_d   = hit_sym;
            sym_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = OUT;
          end else if (ncnt == 3'd7) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            acc_d = nacc;
            cnt_d = ncnt;
          end
        end
      end
      OUT: begin
        if (bus.sym_ready) begin
          sym_valid_d = 1'b0;
          sym_count_d = sym_count_q + 8'd1;
          state_d     = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_ready = (state_q == RUN) && !bus.stop;
  end

  assign bus.bit_ready = bit_ready;
  assign bus.sym_out   = sym_out_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym_count = sym_count_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
